fb_swap_ctrl: RTL and testbench

- Parametrised double-buffered framebuffer controller, successor to the fixed 640x480, 3-bit-colour two-BRAM swapper.
- Sits between the vector draw engine (writer) and the VGA timing generator (reader); holds two internal frame buffers.
- Swaps front/back buffers only at end of visible frame.
- After each swap, clears the new back buffer with an internal sweep engine, so no external BRAM clear pin is needed.

---
 rtl/fb_swap_ctrl.sv | 129 ++++++++++++
 tb/tb_fb_swap_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fb_swap_ctrl.sv
// rtl/fb_swap_ctrl.sv - double-buffered framebuffer, swaps at end of visible frame, sweep-clears new back buffer
module fb_swap_ctrl #(
    parameter int                 H_RES     = 640,
    parameter int                 V_RES     = 480,
    parameter int                 COLOR_W   = 3,
    parameter int                 CLEAR_EN  = 1,
    parameter logic [COLOR_W-1:0] CLEAR_VAL = '0,
    parameter int                 AW        = $clog2(H_RES*V_RES)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [AW-1:0]                 w_addr,
    input  logic [COLOR_W-1:0]            w_data,
    input  logic                          w_en,
    input  logic                          done,
    input  logic [$clog2(V_RES+64)-1:0]   row,
    input  logic [$clog2(H_RES+192)-1:0]  col,
    output logic [3:0]                    red_out,
    output logic [3:0]                    green_out,
    output logic [3:0]                    blue_out,
    output logic                          ready,
    output logic                          swapped,
    output logic                          front_sel
);

    localparam int          NPIX  = H_RES * V_RES;
    localparam logic [31:0] H_LIM = 32'(H_RES);
    localparam logic [31:0] V_LIM = 32'(V_RES);
    localparam logic [31:0] N_LIM = 32'(NPIX);

    typedef enum logic [1:0] {DRAW, PEND, CLEAR} state_t;

    state_t state, state_nx;
    logic   swap;

    logic [COLOR_W-1:0] mem0 [NPIX];
    logic [COLOR_W-1:0] mem1 [NPIX];

    logic [AW-1:0]      clr_cnt;
    logic               sweep_last;
    logic               last_px;
    logic               vis, vis_q, sel_q;
    logic [AW-1:0]      r_addr;
    logic [COLOR_W-1:0] rd0, rd1, pix;
    logic [11:0]        rgb;

    logic               clearing;
    logic               wr_en, we0, we1;
    logic [AW-1:0]      wr_addr;
    logic [COLOR_W-1:0] wr_data;

    assign vis        = (32'(row) < V_LIM) && (32'(col) < H_LIM);
    assign r_addr     = AW'(32'(row) * H_LIM + 32'(col));
    assign last_px    = (32'(row) == V_LIM - 32'd1) && (32'(col) == H_LIM - 32'd1);
    assign sweep_last = (clr_cnt == AW'(NPIX - 1));

    // The back buffer is always the one not on screen; writer and sweep share its port.
    assign clearing = (state == CLEAR);
    assign wr_en    = clearing || (ready && w_en && (32'(w_addr) < N_LIM));
    assign wr_addr  = clearing ? clr_cnt : w_addr;
    assign wr_data  = clearing ? CLEAR_VAL : w_data;
    assign we0      = wr_en && front_sel;
    assign we1      = wr_en && !front_sel;

    always_ff @(posedge clk) begin
        if (we0) mem0[wr_addr] <= wr_data;
        if (vis && !front_sel) rd0 <= mem0[r_addr];
    end

    always_ff @(posedge clk) begin
        if (we1) mem1[wr_addr] <= wr_data;
        if (vis && front_sel) rd1 <= mem1[r_addr];
    end

    always_comb begin
        state_nx = state;
        swap     = 1'b0;
        ready    = 1'b0;
        case (state)
            DRAW: begin
                ready = 1'b1;
                if (done) state_nx = PEND;
            end
            PEND: begin
                if (last_px) begin
                    swap     = 1'b1;
                    state_nx = (CLEAR_EN != 0) ? CLEAR : DRAW;
                end
            end
            CLEAR: begin
                if (sweep_last) state_nx = DRAW;
            end
            default: state_nx = DRAW;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= DRAW;
            front_sel <= 1'b0;
            swapped   <= 1'b0;
            clr_cnt   <= '0;
            vis_q     <= 1'b0;
            sel_q     <= 1'b0;
        end else begin
            state     <= state_nx;
            front_sel <= front_sel ^ swap;
            swapped   <= swap;
            vis_q     <= vis;
            sel_q     <= front_sel;
            if (clearing && !sweep_last) clr_cnt <= clr_cnt + AW'(1);
            else                         clr_cnt <= '0;
        end
    end

    assign pix = sel_q ? rd1 : rd0;

    generate
        if (COLOR_W == 12) begin : g_c12
            assign rgb = pix;
        end else begin : g_c3
            assign rgb = {{4{pix[2]}}, {4{pix[1]}}, {4{pix[0]}}};
        end
    endgenerate

    // Blanking pixels never touched RAM, so the stale read register is masked here.
    assign {red_out, green_out, blue_out} = vis_q ? rgb : 12'h000;

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// tb/tb_fb_swap_ctrl.sv - randomized self-checking bench for fb_swap_ctrl (3-bit and 12-bit instances)
module tb_fb_swap_ctrl;

    localparam int H  = 12;
    localparam int V  = 10;
    localparam int N  = H * V;
    localparam int HT = 16;
    localparam int VT = 14;
    localparam int AW = 7;
    localparam int RW = 7;
    localparam int CW = 8;
    localparam logic [2:0]  CV_A = 3'b000;
    localparam logic [11:0] CV_B = 12'h3C1;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] w_addr;
    logic [11:0]   w_data;
    logic          w_en, done;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [3:0]    red_a, green_a, blue_a, red_b, green_b, blue_b;
    logic          ready_a, swapped_a, front_a, ready_b, swapped_b, front_b;

    always #5 clk = ~clk;

    fb_swap_ctrl #(.H_RES(H), .V_RES(V), .COLOR_W(3), .CLEAR_EN(1), .CLEAR_VAL(CV_A)) dut_a (
        .clk(clk), .rst(rst), .w_addr(w_addr), .w_data(w_data[2:0]), .w_en(w_en), .done(done),
        .row(row), .col(col), .red_out(red_a), .green_out(green_a), .blue_out(blue_a),
        .ready(ready_a), .swapped(swapped_a), .front_sel(front_a));

    fb_swap_ctrl #(.H_RES(H), .V_RES(V), .COLOR_W(12), .CLEAR_EN(1), .CLEAR_VAL(CV_B)) dut_b (
        .clk(clk), .rst(rst), .w_addr(w_addr), .w_data(w_data), .w_en(w_en), .done(done),
        .row(row), .col(col), .red_out(red_b), .green_out(green_b), .blue_out(blue_b),
        .ready(ready_b), .swapped(swapped_b), .front_sel(front_b));

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string nm, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: two pixel arrays, a pending-swap flag and a remaining-sweep count.
    logic [2:0]  ma [2][N];
    logic [11:0] mb [2][N];
    bit          mk [2][N];
    bit          m_pend, e_front, e_swapped, e_vis, e_known, e_ready;
    int          m_clr, m_px;
    logic [2:0]  e_pa;
    logic [11:0] e_pb;

    always @(posedge clk) begin
        if (!rst) begin
            m_pend = 0; m_clr = 0; e_front = 0; e_swapped = 0;
            e_vis = 0; e_known = 1; e_ready = 1;
        end else begin
            e_swapped = 0;
            if (int'(row) < V && int'(col) < H) begin
                m_px    = int'(row) * H + int'(col);
                e_vis   = 1;
                e_pa    = ma[e_front][m_px];
                e_pb    = mb[e_front][m_px];
                e_known = mk[e_front][m_px];
            end else begin
                e_vis   = 0;
                e_known = 1;
            end
            if (m_clr > 0) begin
                m_px = N - m_clr;
                ma[!e_front][m_px] = CV_A;
                mb[!e_front][m_px] = CV_B;
                mk[!e_front][m_px] = 1;
                m_clr--;
            end else if (e_ready && w_en && int'(w_addr) < N) begin
                ma[!e_front][w_addr] = w_data[2:0];
                mb[!e_front][w_addr] = w_data;
                mk[!e_front][w_addr] = 1;
            end
            if (e_ready && done) m_pend = 1;
            else if (m_pend && int'(row) == V - 1 && int'(col) == H - 1) begin
                e_front = !e_front; e_swapped = 1; m_pend = 0; m_clr = N;
            end
            e_ready = !m_pend && m_clr == 0;
        end
    end

    logic [11:0] exp_a, exp_b;
    always @(negedge clk) begin
        check("ready_a", 32'(ready_a), 32'(e_ready));
        check("ready_b", 32'(ready_b), 32'(e_ready));
        check("front_a", 32'(front_a), 32'(e_front));
        check("front_b", 32'(front_b), 32'(e_front));
        check("swapped_a", 32'(swapped_a), 32'(e_swapped));
        check("swapped_b", 32'(swapped_b), 32'(e_swapped));
        if (e_known) begin
            exp_a = e_vis ? {{4{e_pa[2]}}, {4{e_pa[1]}}, {4{e_pa[0]}}} : 12'h000;
            exp_b = e_vis ? e_pb : 12'h000;
            check("rgb_a", 32'({red_a, green_a, blue_a}), 32'(exp_a));
            check("rgb_b", 32'({red_b, green_b, blue_b}), 32'(exp_b));
        end
    end

    int sr = 0, sc = 0;

    task automatic step();
        @(negedge clk);
        row  = RW'(sr);
        col  = CW'(sc);
        w_en = 1'b0;
        done = 1'b0;
        if (sc == HT - 1) begin
            sc = 0;
            sr = (sr == VT - 1) ? 0 : sr + 1;
        end else sc++;
    endtask

    int  cnt, swaps;
    bit  f;

    initial begin
        rst = 1'b0; w_en = 1'b0; done = 1'b0; w_addr = '0; w_data = '0; row = '0; col = '0;
        repeat (3) step();
        check("rst_ready", 32'({ready_a, ready_b}), 32'h3);
        check("rst_front", 32'({front_a, front_b}), 32'h0);
        check("rst_swapped", 32'({swapped_a, swapped_b}), 32'h0);
        check("rst_rgb", 32'({red_a, green_a, blue_a, red_b, green_b, blue_b}), 32'h0);
        rst = 1'b1;

        step(); w_en = 1'b1; w_addr = 7'd5; w_data = 12'hA5D;
        step(); done = 1'b1;
        cnt = 0;
        while (!swapped_a && cnt < 2 * HT * VT) begin
            step(); w_en = 1'b1; w_addr = 7'd5; w_data = 12'h000; cnt++;
        end
        check("swap_seen", 32'(swapped_a), 32'h1);
        check("front_after_swap", 32'({front_a, front_b}), 32'h3);

        cnt = 0; swaps = 0;
        while (!ready_a && cnt < 2 * HT * VT) begin
            if (swapped_a) swaps++;
            step(); w_en = 1'b1; w_addr = AW'($urandom_range(0, 127)); w_data = 12'($urandom); cnt++;
        end
        check("clear_len", cnt, N);
        check("swap_pulses", swaps, 1);
        check("clear_fits_frame", 32'(cnt <= HT * VT), 32'h1);

        cnt = 0;
        do begin step(); cnt++; end while (!(row == 0 && col == 5) && cnt < 2 * HT * VT);
        step();
        check("px5_a", 32'({red_a, green_a, blue_a}), 32'hF0F);
        check("px5_b", 32'({red_b, green_b, blue_b}), 32'hA5D);

        step(); w_en = 1'b1; w_addr = 7'd120; w_data = 12'hFFF;
        step(); w_en = 1'b1; w_addr = 7'd127; w_data = 12'hFFF;
        step(); row = RW'(V - 1); col = CW'(200);
        step();
        check("blank_rgb", 32'({red_a, green_a, blue_a, red_b, green_b, blue_b}), 32'h0);

        cnt = 0;
        do begin step(); cnt++; end while (!(row == RW'(V - 1) && col == CW'(H - 1)) && cnt < 2 * HT * VT);
        done = 1'b1;
        f = front_a;
        step();
        check("done_at_last_px_noswap", 32'({swapped_a, front_a}), 32'({1'b0, f}));
        cnt = 1;
        while (!swapped_a && cnt < 2 * HT * VT) begin step(); cnt++; end
        check("deferred_swap_delay", cnt, HT * VT + 1);
        check("deferred_swap_front", 32'(front_a), 32'(!f));

        repeat (10) step();
        rst = 1'b0;
        step();
        check("midclear_rst_ready", 32'({ready_a, ready_b}), 32'h3);
        check("midclear_rst_front", 32'({front_a, front_b}), 32'h0);
        rst = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            step();
            w_en   = 1'($urandom_range(0, 1));
            w_addr = AW'($urandom_range(0, 127));
            w_data = 12'($urandom);
            done   = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 7) == 0) begin
                row = RW'($urandom_range(0, 20));
                col = CW'($urandom_range(0, 30));
            end
        end
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
